nibble_serial_subtractor: RTL and testbench
===========================================

Name: nibble_serial_subtractor

Overview:
Multi-cycle unsigned/two's-complement subtractor that computes diff = a - b one 4-bit nibble per clock. Each nibble uses a 4-bit carry-look-ahead slice in add-complement form (a + ~b + carry-in), and the borrow is chained between nibbles. This is the subtract counterpart of the team's 4-bit CLA adder, widened to WIDTH bits with a start/busy/done handshake, so wide operands reuse a single small CLA slice.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of 4 and at least 4.
- NIBBLES (localparam), WIDTH/4, number of RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start.
- b  input  WIDTH  subtrahend; captured on the accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; results valid.
- diff  output  WIDTH  a - b mod 2^WIDTH; held until the next completion.
- borrow  output  1  1 iff a < b (unsigned).
- ovf  output  1  signed overflow of a - b.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; busy=0, done=0, diff=0, borrow=0, ovf=0.
  - Internal operand registers, nibble index and borrow chain are cleared.
  - rst has priority over everything else.
  - rst mid-operation aborts the operation: no done pulse, and outputs go to their reset values.
- State machine: IDLE, RUN, DONE.
  - IDLE: when start=1 at an edge, latch a and b, set nibble index k=0 and internal borrow=0, then go to RUN.
  - IDLE: when start=0, stay in IDLE.
  - RUN (busy=1): each edge computes nibble k.
    - {c, s} = a[k] + ~b[k] + ~borrow_in, using the 4-bit CLA: g=a&~b, p=a^~b, carries from g/p look-ahead.
    - Store s in diff_work[k]; set borrow_in = ~c for the next nibble; k increments.
    - After the edge that processes k=NIBBLES-1, load diff, borrow and ovf from the working registers and go to DONE.
  - DONE (done=1, busy=0): lasts exactly one cycle, then the next edge goes to IDLE unconditionally.
- Timing:
  - If start is accepted at edge E0, done is high in the cycle following edge E_NIBBLES (4 cycles for WIDTH=16).
  - Minimum start-to-start period is NIBBLES+2 cycles.
  - With start held high continuously, a new operation is accepted every NIBBLES+2 cycles.
- start while in RUN or DONE is ignored; the operand inputs may change freely after acceptance.
- diff, borrow and ovf change only on entry to DONE (or on rst). They never show partial results during RUN.
- ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), computed from the latched operands.
- borrow = ~carry-out of the final nibble.
- Equal operands give diff=0, borrow=0, ovf=0.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0034, start pulse -> busy high for 4 cycles, then done=1 for one cycle with diff=0x1200, borrow=0, ovf=0.
- a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, ovf=0 (borrow ripples through all 4 nibbles); a=0x1000, b=0x0FFF -> diff=0x0001, borrow=0.
- a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1; a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow=1, ovf=1; a=0xABCD, b=0xABCD -> diff=0x0000, borrow=0, ovf=0.
- Start accepted with a=0x00FF, b=0x000F; during RUN, pulse start with a=0xFFFF, b=0x0001 -> second request ignored, result diff=0x00F0. With start held high, done pulses occur exactly 6 cycles apart.
- Complete one operation (diff=0x1200), then assert rst during the 2nd RUN cycle of a new operation -> next edge busy=0, done=0, diff=0, borrow=0, and no done pulse follows. A subsequent start with a=0x0005, b=0x0003 -> diff=0x0002 after 4 cycles.
- Randomised sweep of 1000 operand pairs against a reference model (a-b, a<b, signed overflow) -> every done pulse matches all three outputs.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: one 4-bit carry-look-ahead slice in
// add-complement form processes one nibble per clock, chaining the borrow.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [KW-1:0]    r_k;
  logic             r_bin;

  logic [KW+1:0]    w_idx;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_sum;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_diff_next;
  logic             w_ovf_next;

  // 4-bit CLA: returns {carry_out, sum} of x + y + cin
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Current nibble slice; the final result merges the last sum into the working word
  always_comb begin
    w_idx             = {r_k, 2'b00};
    w_last            = (r_k == KW'(NIBBLES - 1));
    w_a_nib           = r_a[w_idx +: 4];
    w_b_nib           = r_b[w_idx +: 4];
    {w_cout, w_sum}   = cla4(w_a_nib, ~w_b_nib, ~r_bin);
    w_diff_next       = r_work;
    w_diff_next[w_idx +: 4] = w_sum;
    w_ovf_next        = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                        (w_diff_next[WIDTH-1] != r_a[WIDTH-1]);
  end

  // Operand capture, nibble datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_work <= '0;
      r_k    <= '0;
      r_bin  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      busy <= (w_state_next == S_RUN);
      done <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_k   <= '0;
            r_bin <= 1'b0;
          end
        end
        S_RUN: begin
          r_work[w_idx +: 4] <= w_sum;
          r_bin              <= ~w_cout;
          r_k                <= r_k + KW'(1);
          if (w_last) begin
            diff   <= w_diff_next;
            borrow <= ~w_cout;
            ovf    <= w_ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench: vector table + scoreboard queue, plus handshake corner cases.
module tb_nibble_serial_subtractor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        busy, done, borrow, ovf;
  logic [15:0] diff;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [17:0] exp_q[$];   // {ovf, borrow, diff}

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        br;
    logic        ov;
  } vec_t;
  vec_t vecs[7];

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: diff=0x%0h with no pending request", diff);
      end else begin
        check("result", {14'd0, ovf, borrow, diff}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y);
    int          sd;
    logic [15:0] d;
    d  = x - y;
    sd = int'($signed(x)) - int'($signed(y));
    return {((sd > 32767) || (sd < -32768)), (x < y), d};
  endfunction

  // One operation; checks busy width and done latency
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic [17:0] exp);
    int cyc;
    int nbusy;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    a = $urandom(); b = $urandom();
    cyc = 0; nbusy = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      cyc++;
    end
    check("done_latency", cyc, 4);
    check("busy_cycles", nbusy, 4);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int t[3];
    int n;
    int cyc;
    logic [15:0] rx, ry;

    vecs[0] = '{16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h1000, 16'h0FFF, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
    vecs[5] = '{16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b0};
    vecs[6] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {11'd0, busy, done, borrow, ovf, diff}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, {vecs[i].ov, vecs[i].br, vecs[i].d});

    // Start during RUN is ignored
    @(negedge clk);
    a = 16'h00FF; b = 16'h000F; start = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 16'h00F0});
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("ignored_start_q", exp_q.size(), 0);

    // Start held high: done pulses 6 cycles apart
    @(negedge clk);
    a = 16'h0005; b = 16'h0003; start = 1'b1;
    repeat (3) exp_q.push_back({1'b0, 1'b0, 16'h0002});
    n = 0; cyc = 0;
    while (n < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        t[n] = cyc;
        n++;
      end
    end
    start = 1'b0;
    check("held_done_count", n, 3);
    if (n == 3) begin
      check("held_period_1", t[1] - t[0], 6);
      check("held_period_2", t[2] - t[1], 6);
    end
    @(negedge clk);

    // Reset in the 2nd RUN cycle aborts the operation
    run_op(16'h1234, 16'h0034, {1'b0, 1'b0, 16'h1200});
    a = 16'hFFFF; b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", {11'd0, busy, done, borrow, ovf, diff}, 32'd0);
    rst = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    check("abort_no_done", n, 0);
    run_op(16'h0005, 16'h0003, {1'b0, 1'b0, 16'h0002});

    // Random sweep
    for (int i = 0; i < 1000; i++) begin
      rx = 16'($urandom());
      ry = 16'($urandom());
      if (i % 16 == 0) ry = rx;
      run_op(rx, ry, model(rx, ry));
    end

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
